ps2_keyboard_fsm: RTL and testbench
===================================

# ps2_keyboard_fsm

PS/2 keyboard receiver and scan-code decoder. Samples the keyboard clock/data lines, assembles 11-bit frames, decodes Set-2 make/break sequences, and presents the ASCII code of the currently held key on a level output. The game's state machine and character-removal logic consume this output: Enter starts and restarts the game, letters remove falling characters, and the idle code re-arms removal.

## Interface
- `IDLE_CODE`, default 8'h31: value driven on `ascii` when no mapped key is held.
- `TIMEOUT`, default 50000: `clk` cycles without a `ps2_clk` falling edge after which a partial frame is discarded.
- `clk` input 1: system clock, 50 MHz. All logic is in this single domain.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `ps2_clk` inout 1: keyboard clock. Never driven; the block holds it at high-Z and only reads it.
- `ps2_data` inout 1: keyboard data. Never driven; high-Z, read only.
- `ascii` output 8: ASCII of the held key, `IDLE_CODE` when no mapped key is held, or 8'h00 while an unmapped key is held.

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. A third register on the clock line detects falling edges.
- **Frame format:** 11 bits, one sampled per `ps2_clk` falling edge:
  - start bit = 0
  - 8 data bits, LSB first
  - odd parity bit
  - stop bit = 1
- **Frame acceptance:** the frame is accepted only if start = 0, stop = 1, and parity is odd across the 9 bits (data plus parity). A rejected frame is dropped silently and has no effect on decoder state.
- **Timeout:** if a frame is partially received and no falling edge arrives for `TIMEOUT` cycles, the bit counter resets to 0.
- **Decoder states:**
  - `IDLE`: no key held.
  - `HELD`: a key is held; its code is stored.
  - `BRK`: F0 received.
  - `EXT`: E0 received.
  - `EXT_BRK`: E0 F0 received.
- **Transitions on each accepted byte:**
  - In `IDLE` or `HELD`:
    - byte E0 → `EXT`.
    - byte F0 → `BRK`.
    - any other byte → `HELD`. Store the code and set `ascii` = map(code).
  - In `BRK`: the byte is a break code.
    - If it equals the stored held code → `IDLE`, `ascii` = `IDLE_CODE`.
    - Otherwise return to the previous state (`HELD` or `IDLE`) with `ascii` unchanged.
  - In `EXT`:
    - byte F0 → `EXT_BRK`.
    - any other byte → return to the previous state, `ascii` unchanged. Extended keys are unmapped and ignored entirely.
  - In `EXT_BRK`: any byte → return to the previous state, `ascii` unchanged.
- **Typematic repeat:** a repeated make of the held key leaves `ascii` unchanged.
- **Rollover:**
  - A new make while a key is held switches `ascii` to the new key and replaces the stored code.
  - A break of the older key is then ignored, because only the most recent key's break returns to idle.
- **Key map (Set 2 → ASCII):**
  - Letters map to uppercase:
    - A=1C→41, B=32, C=21, D=23, E=24, F=2B, G=34
    - H=33, I=43, J=3B, K=42, L=4B, M=3A, N=31
    - O=44, P=4D, Q=15, R=2D, S=1B, T=2C, U=3C
    - V=2A, W=1D, X=22, Y=35, Z=1A→5A
  - Enter 5A → 8'h0D.
  - Every other code maps to 8'h00.
- **Reset:** asynchronous, active-low. Sets:
  - `ascii` = `IDLE_CODE`
  - state = `IDLE`
  - bit counter and shift register = 0
  - timeout counter = 0
  - synchronisers = 1

## Timing
- `ascii` is a registered output and changes only on `clk` rising edges.
- **Latency:** `ascii` takes its new value exactly 4 `clk` cycles after the stop bit's `ps2_clk` falling edge at the pin:
  - 2 cycles for the synchroniser
  - 1 cycle for edge detection
  - 1 cycle for the output register
- Data is sampled on the same cycle the synchronised falling edge is detected.
- Minimum `ps2_clk` half-period supported: 8 `clk` cycles. Real keyboards run at 30–50 µs.
- Reset asserted mid-frame discards the partial frame. The first complete frame after deassertion decodes normally.
- No glitch filtering beyond the synchroniser.

## Test plan
- Reset, then hold the lines high for 100 cycles → `ascii` = 8'h31 throughout.
- Send frames 1C, then F0 1C → `ascii` = 8'h41 within 4 cycles of the first stop edge, then 8'h31 after the second break byte.
- Send 5A, 5A, 5A (typematic), then F0 5A → `ascii` = 8'h0D, stable through the repeats, then 8'h31.
- Send a 1C frame with even parity, and one with stop = 0 → `ascii` stays 8'h31. A following valid 15 gives 8'h51.
- Rollover and extended keys:
  - Send 1C, 32, F0 1C → `ascii` = 8'h42 (break of A ignored).
  - Then F0 32 → 8'h31.
  - Then E0 75, E0 F0 75 → 8'h31 unchanged.
- Send 5 bits of a frame, stall for `TIMEOUT`+10 cycles, then send a full 24 frame → `ascii` = 8'h45.
- Assert `rst` while 2B is held → `ascii` = 8'h31 immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/ps2_keyboard_fsm_if.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_fsm_if
//
// Bundles the PS/2 keyboard lines together with the decoded key output.
//
// Signals:
//   ps2_clk  - keyboard clock line. The receiver only reads it and never
//              drives it, so on the board it stays high-Z from our side.
//   ps2_data - keyboard data line. Read only, never driven by the receiver.
//   ascii    - ASCII code of the currently held key, produced by the receiver.
//
// Modports:
//   master - keyboard side: drives the PS/2 lines and observes ascii.
//   slave  - receiver side: reads the PS/2 lines and drives ascii.
// ---------------------------------------------------------------------------
interface ps2_keyboard_fsm_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ascii
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ascii
    );
endinterface

// File: rtl/ps2_keyboard_fsm.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_fsm
//
// PS/2 keyboard receiver and Set-2 scan-code decoder. Synchronises the
// keyboard lines into the clk domain, assembles 11-bit frames, checks them,
// tracks make/break/extended sequences and presents the ASCII code of the
// most recently pressed, still-held key as a registered level.
//
// Parameters:
//   IDLE_CODE - value on ascii while no key is held.
//   TIMEOUT   - clk cycles without a ps2_clk falling edge after which a
//               partially received frame is thrown away.
//
// Ports:
//   clk  - 50 MHz system clock; the only clock domain.
//   rst  - asynchronous reset, active low.
//   ps2  - interface (slave modport): ps2_clk / ps2_data read only,
//          ascii = held key's ASCII, IDLE_CODE when idle, 8'h00 when an
//          unmapped key is held.
// ---------------------------------------------------------------------------
module ps2_keyboard_fsm #(
    parameter logic [7:0]  IDLE_CODE = 8'h31,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_keyboard_fsm_if.slave  ps2
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    logic          ps2_clk_s1, ps2_clk_s2, ps2_clk_s3;
    logic          ps2_data_s1, ps2_data_s2;
    logic          clk_fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift_reg;
    logic [TW-1:0] timeout_cnt;
    logic          frame_ok;
    logic          byte_valid;
    logic [7:0]    rx_byte;

    state_t        state, state_next;
    logic [7:0]    held_code, held_code_next;
    logic          held_valid, held_valid_next;
    logic [7:0]    ascii_q, ascii_next;

    // Set-2 make code to ASCII. Letters come out as uppercase, Enter as CR,
    // everything else as 0 so the game can tell "some other key" from idle.
    function automatic logic [7:0] key_map(input logic [7:0] code);
        logic [7:0] result;
        case (code)
            8'h1C: result = 8'h41;
            8'h32: result = 8'h42;
            8'h21: result = 8'h43;
            8'h23: result = 8'h44;
            8'h24: result = 8'h45;
            8'h2B: result = 8'h46;
            8'h34: result = 8'h47;
            8'h33: result = 8'h48;
            8'h43: result = 8'h49;
            8'h3B: result = 8'h4A;
            8'h42: result = 8'h4B;
            8'h4B: result = 8'h4C;
            8'h3A: result = 8'h4D;
            8'h31: result = 8'h4E;
            8'h44: result = 8'h4F;
            8'h4D: result = 8'h50;
            8'h15: result = 8'h51;
            8'h2D: result = 8'h52;
            8'h1B: result = 8'h53;
            8'h2C: result = 8'h54;
            8'h3C: result = 8'h55;
            8'h2A: result = 8'h56;
            8'h1D: result = 8'h57;
            8'h22: result = 8'h58;
            8'h35: result = 8'h59;
            8'h1A: result = 8'h5A;
            8'h5A: result = 8'h0D;
            default: result = 8'h00;
        endcase
        return result;
    endfunction

    // The third clock-line register only exists to spot a 1->0 step of the
    // already synchronised keyboard clock.
    assign clk_fall = ps2_clk_s3 & ~ps2_clk_s2;

    // On the eleventh edge the shift register holds start in bit 0, data in
    // bits 8:1 and parity in bit 9; the stop bit is still on the data line.
    assign frame_ok = ~shift_reg[0] & ps2_data_s2 & (^shift_reg[9:1]);

    // Synchronisers, frame assembly and the stall timeout. A good frame
    // raises byte_valid for one cycle with the data byte in rx_byte; a bad
    // one just clears the assembly state so the decoder never sees it.
    // The timeout only runs while a frame is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2_clk_s1  <= 1'b1;
            ps2_clk_s2  <= 1'b1;
            ps2_clk_s3  <= 1'b1;
            ps2_data_s1 <= 1'b1;
            ps2_data_s2 <= 1'b1;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            timeout_cnt <= '0;
            byte_valid  <= 1'b0;
            rx_byte     <= '0;
        end else begin
            ps2_clk_s1  <= ps2.ps2_clk;
            ps2_clk_s2  <= ps2_clk_s1;
            ps2_clk_s3  <= ps2_clk_s2;
            ps2_data_s1 <= ps2.ps2_data;
            ps2_data_s2 <= ps2_data_s1;
            byte_valid  <= 1'b0;
            if (clk_fall) begin
                timeout_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shift_reg[8:1];
                    end
                end else begin
                    shift_reg <= {ps2_data_s2, shift_reg[9:1]};
                    bit_cnt   <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (timeout_cnt == TW'(TIMEOUT - 1)) begin
                    bit_cnt     <= '0;
                    shift_reg   <= '0;
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

    // Decoder state register together with the remembered held key and the
    // registered ascii output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            held_code  <= '0;
            held_valid <= 1'b0;
            ascii_q    <= IDLE_CODE;
        end else begin
            state      <= state_next;
            held_code  <= held_code_next;
            held_valid <= held_valid_next;
            ascii_q    <= ascii_next;
        end
    end

    // Make/break decoding. held_valid tells prefix states whether to fall
    // back to HELD or IDLE once the sequence is consumed. Only a break of the
    // most recently made key releases it, so rollover leaves the newest key
    // on the output even when the older one is let go.
    always_comb begin
        state_next      = state;
        held_code_next  = held_code;
        held_valid_next = held_valid;
        ascii_next      = ascii_q;
        if (byte_valid) begin
            case (state)
                IDLE, HELD: begin
                    if (rx_byte == 8'hE0) begin
                        state_next = EXT;
                    end else if (rx_byte == 8'hF0) begin
                        state_next = BRK;
                    end else begin
                        state_next      = HELD;
                        held_code_next  = rx_byte;
                        held_valid_next = 1'b1;
                        ascii_next      = key_map(rx_byte);
                    end
                end
                BRK: begin
                    if (held_valid && (rx_byte == held_code)) begin
                        state_next      = IDLE;
                        held_valid_next = 1'b0;
                        ascii_next      = IDLE_CODE;
                    end else begin
                        state_next = held_valid ? HELD : IDLE;
                    end
                end
                EXT: begin
                    if (rx_byte == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else begin
                        state_next = held_valid ? HELD : IDLE;
                    end
                end
                EXT_BRK: begin
                    state_next = held_valid ? HELD : IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign ps2.ascii = ascii_q;

endmodule

// File: tb/tb_ps2_keyboard_fsm.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_fsm
//
// Drives PS/2 frames into ps2_keyboard_fsm through its interface and checks
// the ascii output every cycle against a sequence-level keyboard model, plus
// hand-computed values after each scenario.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_fsm;

    localparam int         HP   = 10;
    localparam int         TMO  = 1000;
    localparam logic [7:0] IDLE = 8'h31;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_ascii = IDLE;
    int         held_key    = -1;
    logic [7:0] seq[$];

    ps2_keyboard_fsm_if ps2_bus ();

    ps2_keyboard_fsm #(
        .IDLE_CODE(IDLE),
        .TIMEOUT  (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2(ps2_bus)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: ascii=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Keyboard key table: letter index i is ASCII 'A'+i.
    function automatic logic [7:0] keyMap(input logic [7:0] code);
        logic [7:0] codes [26];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        for (int i = 0; i < 26; i++)
            if (codes[i] == code) return 8'h41 + 8'(i);
        if (code == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    // Model: collect bytes until they form a complete scan-code sequence
    // (make, F0 x, E0 x, E0 F0 x), then apply its effect on the held key.
    task automatic modelByte(input logic [7:0] b);
        seq.push_back(b);
        if (seq[0] == 8'hF0) begin
            if (seq.size() == 2) begin
                if (held_key >= 0 && int'(seq[1]) == held_key) begin
                    held_key    = -1;
                    model_ascii = IDLE;
                end
                seq.delete();
            end
        end else if (seq[0] == 8'hE0) begin
            if ((seq.size() == 2 && seq[1] != 8'hF0) || seq.size() == 3)
                seq.delete();
        end else begin
            held_key    = int'(seq[0]);
            model_ascii = keyMap(seq[0]);
            seq.delete();
        end
    endtask

    task automatic modelReset();
        held_key    = -1;
        model_ascii = IDLE;
        seq.delete();
    endtask

    // Sends one 11-bit frame. The model sees the byte (if the frame is
    // well formed) three system cycles after the stop edge, so the new value
    // is expected from the fourth rising clk edge onward.
    task automatic applyStimulus(input logic [7:0] data, input bit bad_parity,
                                 input bit bad_stop);
        logic [10:0] bits;
        bit          accept;
        bits   = {~bad_stop, (~^data) ^ bad_parity, data, 1'b0};
        accept = (bits[0] == 1'b0) && (bits[10] == 1'b1) && (^bits[9:1] == 1'b1);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_bus.ps2_data = bits[i];
            repeat (HP - 1) @(negedge clk);
            ps2_bus.ps2_clk = 1'b0;
            if (i == 10) begin
                repeat (3) @(negedge clk);
                if (accept) modelByte(data);
                repeat (HP - 3) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            ps2_bus.ps2_clk = 1'b1;
        end
        ps2_bus.ps2_data = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    // Sends only the first nbits of a frame (start bit first).
    task automatic sendPartial(input logic [7:0] data, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, ~^data, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_bus.ps2_data = bits[i];
            repeat (HP - 1) @(negedge clk);
            ps2_bus.ps2_clk = 1'b0;
            repeat (HP) @(negedge clk);
            ps2_bus.ps2_clk = 1'b1;
        end
        ps2_bus.ps2_data = 1'b1;
    endtask

    // Every cycle, just after the rising edge, the DUT must match the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("model_cycle", ps2_bus.ascii, model_ascii);
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        ps2_bus.ps2_clk  = 1'b1;
        ps2_bus.ps2_data = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_value", ps2_bus.ascii, 8'h31);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("idle_lines", ps2_bus.ascii, 8'h31);

        applyStimulus(8'h1C, 0, 0);
        checkOutput("make_A", ps2_bus.ascii, 8'h41);
        applyStimulus(8'hF0, 0, 0);
        checkOutput("break_prefix", ps2_bus.ascii, 8'h41);
        applyStimulus(8'h1C, 0, 0);
        checkOutput("break_A", ps2_bus.ascii, 8'h31);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h5A, 0, 0);
            checkOutput("enter_repeat", ps2_bus.ascii, 8'h0D);
        end
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h5A, 0, 0);
        checkOutput("break_enter", ps2_bus.ascii, 8'h31);

        applyStimulus(8'h1C, 1, 0);
        checkOutput("bad_parity", ps2_bus.ascii, 8'h31);
        applyStimulus(8'h1C, 0, 1);
        checkOutput("bad_stop", ps2_bus.ascii, 8'h31);
        applyStimulus(8'h15, 0, 0);
        checkOutput("make_Q", ps2_bus.ascii, 8'h51);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h15, 0, 0);
        checkOutput("break_Q", ps2_bus.ascii, 8'h31);

        applyStimulus(8'h1C, 0, 0);
        applyStimulus(8'h32, 0, 0);
        checkOutput("rollover_B", ps2_bus.ascii, 8'h42);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1C, 0, 0);
        checkOutput("old_break_ignored", ps2_bus.ascii, 8'h42);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h32, 0, 0);
        checkOutput("break_B", ps2_bus.ascii, 8'h31);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        checkOutput("extended_ignored", ps2_bus.ascii, 8'h31);

        applyStimulus(8'h76, 0, 0);
        checkOutput("unmapped_make", ps2_bus.ascii, 8'h00);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h76, 0, 0);
        checkOutput("unmapped_break", ps2_bus.ascii, 8'h31);

        sendPartial(8'h24, 5);
        repeat (TMO + 10) @(negedge clk);
        applyStimulus(8'h24, 0, 0);
        checkOutput("after_timeout_E", ps2_bus.ascii, 8'h45);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h24, 0, 0);
        checkOutput("break_E", ps2_bus.ascii, 8'h31);

        applyStimulus(8'h2B, 0, 0);
        checkOutput("make_F", ps2_bus.ascii, 8'h46);
        sendPartial(8'h1C, 3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", ps2_bus.ascii, 8'h31);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(8'h1C, 0, 0);
        checkOutput("after_reset_A", ps2_bus.ascii, 8'h41);

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
